// File: rtl/nios2_ocimem_pkg.sv
// Shared types and widths for the OCI debug-memory arbiter.
package nios2_ocimem_pkg;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_CPU_RSP,
    ST_CPU_WR,
    ST_JTAG_RD,
    ST_JTAG_RSP,
    ST_JTAG_WR
  } ocimem_state_e;
endpackage

// File: rtl/nios2_ocimem_jtag_ptr.sv
// JTAG side bookkeeping: pending access latch, auto-incrementing address
// pointer and the sticky protocol-error flag.
module nios2_ocimem_jtag_ptr
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_addr_set,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              done,
  output logic              pending,
  output logic              wr_q,
  output logic [DATA_W-1:0] wdata_q,
  output logic [ADDR_W-1:0] ptr,
  output logic              mon_error
);

  // pending stays set until the RAM cycle finishes, so it also covers "in flight".
  always_ff @(posedge clk) begin
    if (reset) begin
      pending   <= 1'b0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      ptr       <= '0;
      mon_error <= 1'b0;
    end else begin
      if (jtag_addr_set) begin
        if (!pending) begin
          ptr       <= jtag_addr;
          mon_error <= 1'b0;
        end else begin
          mon_error <= 1'b1;
        end
      end
      if (jtag_req) begin
        if (!pending) begin
          pending <= 1'b1;
          wr_q    <= jtag_wr;
          wdata_q <= jtag_wdata;
        end else begin
          mon_error <= 1'b1;
        end
      end
      if (done) begin
        pending <= 1'b0;
        ptr     <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI RAM between JTAG (fixed priority) and the CPU
// Avalon slave, with a starvation guard. Optional: OCIMEM_ROM_PROTECT_EN.
module nios2_ocimem_arbiter
  import nios2_ocimem_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_addr_set,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_req,
  input  logic              jtag_wr,
  input  logic [31:0]       jtag_wdata,
  output logic [31:0]       mon_dreg,
  output logic              mon_ready,
  output logic              mon_error,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  ocimem_state_e     state;
  logic [3:0]        starve;
  logic              ram_wren_q;
  logic              pending, wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [ADDR_W-1:0] ptr;
  logic              cpu_req, jtag_done, cpu_wr_en;

  assign cpu_req   = avs_read | avs_write;
  assign jtag_done = (state == ST_JTAG_WR) || (state == ST_JTAG_RSP);

`ifdef OCIMEM_ROM_PROTECT_EN
  // Upper half of the CPU window is read-only; the write still handshakes.
  assign cpu_wr_en = ~avs_address[ADDR_W-1];
`else
  assign cpu_wr_en = 1'b1;
`endif

  nios2_ocimem_jtag_ptr #(.ADDR_W(ADDR_W)) u_jtag_ptr (
    .clk           (clk),
    .reset         (reset),
    .jtag_addr_set (jtag_addr_set),
    .jtag_addr     (jtag_addr),
    .jtag_req      (jtag_req),
    .jtag_wr       (jtag_wr),
    .jtag_wdata    (jtag_wdata),
    .done          (jtag_done),
    .pending       (pending),
    .wr_q          (wr_q),
    .wdata_q       (wdata_q),
    .ptr           (ptr),
    .mon_error     (mon_error)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      starve     <= '0;
      mon_dreg   <= '0;
      ram_wren_q <= 1'b0;
      ram_addr   <= '0;
      ram_byteen <= '0;
      ram_wdata  <= '0;
    end else begin
      ram_wren_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pending && (!cpu_req || starve < STARVE_LIM)) begin
            state      <= wr_q ? ST_JTAG_WR : ST_JTAG_RD;
            ram_addr   <= ptr;
            ram_byteen <= 4'hF;
            ram_wdata  <= wdata_q;
            ram_wren_q <= wr_q;
            if (cpu_req && starve != 4'hF) starve <= starve + 4'd1;
          end else if (cpu_req) begin
            starve     <= '0;
            ram_addr   <= avs_address;
            ram_byteen <= avs_byteenable;
            ram_wdata  <= avs_writedata;
            if (avs_write) begin
              state      <= ST_CPU_WR;
              ram_wren_q <= cpu_wr_en;
            end else begin
              state <= ST_CPU_RD;
            end
          end
        end
        ST_CPU_RD:   state <= ST_CPU_RSP;
        ST_JTAG_RD:  state <= ST_JTAG_RSP;
        ST_JTAG_RSP: begin
          mon_dreg <= ram_rdata;
          state    <= ST_IDLE;
        end
        ST_JTAG_WR: begin
          mon_dreg <= wdata_q;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Masking with reset guarantees no RAM write lands in a reset cycle.
  assign ram_wren        = ram_wren_q & ~reset;
  assign mon_ready       = ~pending;
  assign avs_readdata    = ram_rdata;
  assign avs_waitrequest = cpu_req & ~((state == ST_CPU_WR) || (state == ST_CPU_RSP));

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed bench for nios2_ocimem_arbiter with a behavioural 1-cycle RAM.
module tb_nios2_ocimem_arbiter;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          jtag_addr_set, jtag_req, jtag_wr;
  logic [AW-1:0] jtag_addr;
  logic [31:0]   jtag_wdata, mon_dreg;
  logic          mon_ready, mon_error;
  logic [AW-1:0] avs_address;
  logic          avs_read, avs_write, avs_waitrequest;
  logic [31:0]   avs_writedata, avs_readdata;
  logic [3:0]    avs_byteenable;
  logic [AW-1:0] ram_addr;
  logic          ram_wren;
  logic [3:0]    ram_byteen;
  logic [31:0]   ram_wdata, ram_rdata;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] mem [0:255];

  nios2_ocimem_arbiter #(.ADDR_W(AW), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .jtag_addr_set(jtag_addr_set), .jtag_addr(jtag_addr), .jtag_req(jtag_req),
    .jtag_wr(jtag_wr), .jtag_wdata(jtag_wdata),
    .mon_dreg(mon_dreg), .mon_ready(mon_ready), .mon_error(mon_error),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
    .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
    .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_wren)
      for (int b = 0; b < 4; b++)
        if (ram_byteen[b]) mem[ram_addr][8*b +: 8] = ram_wdata[8*b +: 8];
  end

  function automatic logic [31:0] iv(input int i);
    logic [7:0] b;
    b = i[7:0];
    return {8'hA5, 8'h00, b, b};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!mon_ready && n < 30) begin
      step;
      n++;
    end
    chk(tag, 32'(mon_ready), 32'd1);
  endtask

  task automatic jtag_op(input logic set, input logic [7:0] a, input logic wr,
                         input logic [31:0] d, input string tag);
    jtag_addr_set = set; jtag_addr = a; jtag_req = 1'b1; jtag_wr = wr; jtag_wdata = d;
    step;
    jtag_addr_set = 1'b0; jtag_req = 1'b0;
    chk({tag, "_busy"}, 32'(mon_ready), 32'd0);
    wait_ready({tag, "_rdy"});
  endtask

  task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [31:0] d,
                        input logic [3:0] be, output int lat, output logic [31:0] rd);
    avs_address = a; avs_write = wr; avs_read = !wr; avs_writedata = d; avs_byteenable = be;
    #1;
    lat = 1;
    while (avs_waitrequest && lat < 30) begin
      step;
      lat++;
    end
    rd = avs_readdata;
    avs_read = 1'b0; avs_write = 1'b0;
    step;
  endtask

  initial begin
    int lat;
    int n;
    logic [31:0] rd;

    for (int i = 0; i < 256; i++) mem[i] = iv(i);
    mem[8'h20] = 32'h12345678;
    mem[8'h11] = 32'h11111111;
    mem[8'hFF] = 32'hFFFF0000;
    mem[8'h00] = 32'h00C0FFEE;

    reset = 1'b1;
    jtag_addr_set = 0; jtag_addr = '0; jtag_req = 0; jtag_wr = 0; jtag_wdata = '0;
    avs_address = '0; avs_read = 0; avs_write = 0; avs_writedata = '0; avs_byteenable = '0;
    step; step;
    chk("rst_ready", 32'(mon_ready), 32'd1);
    chk("rst_error", 32'(mon_error), 32'd0);
    chk("rst_dreg", mon_dreg, 32'd0);
    chk("rst_wren", 32'(ram_wren), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wait", 32'(avs_waitrequest), 32'd0);
    reset = 1'b0;
    step;

    // JTAG write with address load in the same cycle
    jtag_addr_set = 1; jtag_addr = 8'h10; jtag_req = 1; jtag_wr = 1; jtag_wdata = 32'hDEADBEEF;
    step;
    jtag_addr_set = 0; jtag_req = 0;
    chk("jw_busy", 32'(mon_ready), 32'd0);
    step;
    chk("jw_wren", 32'(ram_wren), 32'd1);
    chk("jw_addr", 32'(ram_addr), 32'h10);
    chk("jw_be", 32'(ram_byteen), 32'hF);
    step;
    chk("jw_ready3", 32'(mon_ready), 32'd1);
    chk("jw_dreg", mon_dreg, 32'hDEADBEEF);
    chk("jw_mem", mem[8'h10], 32'hDEADBEEF);
    jtag_op(0, 8'h00, 0, 32'h0, "jr_inc");
    chk("jr_inc_dreg", mon_dreg, 32'h11111111);
    jtag_op(1, 8'h10, 0, 32'h0, "jr10");
    chk("jr10_dreg", mon_dreg, 32'hDEADBEEF);

    // CPU accesses, no JTAG traffic
    cpu_op(0, 8'h20, 32'h0, 4'hF, lat, rd);
    chk("cr_lat", 32'(lat), 32'd3);
    chk("cr_data", rd, 32'h12345678);
    cpu_op(1, 8'h21, 32'hCAFEF00D, 4'b0101, lat, rd);
    chk("cw_lat", 32'(lat), 32'd2);
    chk("cw_mem", mem[8'h21], 32'hA5FE210D);
    cpu_op(0, 8'h21, 32'h0, 4'hF, lat, rd);
    chk("cw_rd", rd, 32'hA5FE210D);
    chk("nowait", 32'(avs_waitrequest), 32'd0);

    // CPU read held against back-to-back JTAG writes
    fork
      begin
        jtag_op(1, 8'h40, 1, 32'h40400001, "bb0");
        jtag_op(0, 8'h00, 1, 32'h40400002, "bb1");
        jtag_op(0, 8'h00, 1, 32'h40400003, "bb2");
      end
      begin
        step;
        cpu_op(0, 8'h20, 32'h0, 4'hF, lat, rd);
      end
    join
    chk("st_lat", 32'(lat), 32'd5);
    chk("st_data", rd, 32'h12345678);
    chk("st_m40", mem[8'h40], 32'h40400001);
    chk("st_m41", mem[8'h41], 32'h40400002);
    chk("st_m42", mem[8'h42], 32'h40400003);
    chk("st_err", 32'(mon_error), 32'd0);

    // Busy-time strobes are dropped and flag an error
    jtag_op(1, 8'h30, 0, 32'h0, "e0");
    chk("e0_dreg", mon_dreg, 32'hA5003030);
    jtag_req = 1; jtag_wr = 0;
    step;
    jtag_req = 1; jtag_addr_set = 1; jtag_addr = 8'h50;
    step;
    jtag_req = 0; jtag_addr_set = 0;
    chk("e1_err", 32'(mon_error), 32'd1);
    wait_ready("e1_rdy");
    chk("e1_dreg", mon_dreg, 32'hA5003131);
    jtag_op(0, 8'h00, 0, 32'h0, "e2");
    chk("e2_dreg", mon_dreg, 32'hA5003232);
    chk("e2_err", 32'(mon_error), 32'd1);
    jtag_addr_set = 1; jtag_addr = 8'hFF;
    step;
    jtag_addr_set = 0;
    chk("e3_clr", 32'(mon_error), 32'd0);

    // Pointer wrap
    jtag_op(0, 8'h00, 0, 32'h0, "wr0");
    chk("wrap_ff", mon_dreg, 32'hFFFF0000);
    jtag_op(0, 8'h00, 0, 32'h0, "wr1");
    chk("wrap_00", mon_dreg, 32'h00C0FFEE);

    // Reset in CPU_RD with a JTAG write pending
    avs_address = 8'h20; avs_read = 1; avs_byteenable = 4'hF;
    jtag_addr_set = 1; jtag_addr = 8'h60; jtag_req = 1; jtag_wr = 1; jtag_wdata = 32'h600D600D;
    step;
    jtag_addr_set = 0; jtag_req = 0;
    chk("rr_busy", 32'(mon_ready), 32'd0);
    reset = 1;
    step;
    chk("rr_ready", 32'(mon_ready), 32'd1);
    chk("rr_wren", 32'(ram_wren), 32'd0);
    chk("rr_wait", 32'(avs_waitrequest), 32'd1);
    chk("rr_dreg", mon_dreg, 32'd0);
    reset = 0;
    n = 0;
    while (avs_waitrequest && n < 30) begin
      step;
      n++;
    end
    chk("rr_lat", 32'(n), 32'd2);
    chk("rr_data", avs_readdata, 32'h12345678);
    avs_read = 0;
    step; step; step;
    chk("rr_m60", mem[8'h60], 32'hA5006060);

    // Reset landing on the JTAG_WR cycle suppresses the write
    jtag_addr_set = 1; jtag_addr = 8'h70; jtag_req = 1; jtag_wr = 1; jtag_wdata = 32'h77777777;
    step;
    jtag_addr_set = 0; jtag_req = 0;
    step;
    chk("rw_pre", 32'(ram_wren), 32'd1);
    reset = 1;
    #1;
    chk("rw_wren", 32'(ram_wren), 32'd0);
    step;
    reset = 0;
    step;
    chk("rw_m70", mem[8'h70], 32'hA5007070);
    chk("rw_ready", 32'(mon_ready), 32'd1);

    // Upper-half CPU write vs JTAG write
    cpu_op(1, 8'h80, 32'h00000055, 4'hF, lat, rd);
    chk("rp_lat", 32'(lat), 32'd2);
`ifdef OCIMEM_ROM_PROTECT_EN
    chk("rp_cpu", mem[8'h80], 32'hA5008080);
`else
    chk("rp_cpu", mem[8'h80], 32'h00000055);
`endif
    jtag_op(1, 8'h80, 1, 32'h000055AA, "rpj");
    chk("rp_jtag", mem[8'h80], 32'h000055AA);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/nios2_ocimem_arbiter.md
Name: nios2_ocimem_arbiter

Overview:
Arbitrates the shared single-port on-chip debug memory (OCI RAM) between the JTAG debug path and the CPU's Avalon debug-memory slave port. The JTAG side issues accesses as single-cycle action strobes, carrying a command, an address and data, from the debug-slave sysclk domain. The CPU side issues standard Avalon reads and writes. The block sequences RAM cycles, applies fixed JTAG priority with a CPU starvation guard, auto-increments the JTAG address, and returns read data to both sides.

Parameters:
ADDR_W, 8, RAM word-address width (depth 2^ADDR_W x 32).
STARVE_MAX, 4, consecutive denied CPU-request cycles before the CPU is forced a grant (1..15).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
jtag_addr_set  in  1  strobe: load JTAG address pointer from jtag_addr
jtag_addr  in  ADDR_W  new JTAG address
jtag_req  in  1  strobe: request one JTAG access at the pointer
jtag_wr  in  1  qualifies jtag_req: 1=write, 0=read
jtag_wdata  in  32  JTAG write data
mon_dreg  out  32  JTAG read-back / last-written data register
mon_ready  out  1  1 = no JTAG access pending or in flight
mon_error  out  1  sticky: JTAG protocol error
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_byteenable  in  4  CPU byte enables
avs_readdata  out  32  CPU read data
avs_waitrequest  out  1  Avalon waitrequest
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write enable
ram_byteen  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data, 1-cycle registered latency

Behaviour:
- Reset: state=IDLE, pointer=0, pending=0, starve=0, mon_dreg=0, mon_ready=1, mon_error=0, ram_wren=0, ram_addr=0, ram_byteen=0, ram_wdata=0. avs_readdata is a don't-care. avs_waitrequest stays combinational during reset.
- JTAG pending latch:
  - jtag_req sets pending and latches jtag_wr and jtag_wdata. mon_ready falls the next cycle.
  - jtag_req while pending or in flight: request dropped, mon_error set.
- JTAG address pointer:
  - jtag_addr_set while mon_ready=1 loads the pointer.
  - jtag_addr_set with jtag_req in the same cycle: the address loads first, and the access uses the new address.
  - jtag_addr_set while busy: ignored, mon_error set.
  - mon_error clears only on reset or on an accepted jtag_addr_set.
- FSM states: IDLE, CPU_RD, CPU_RSP, CPU_WR, JTAG_RD, JTAG_RSP, JTAG_WR.
- IDLE grant:
  - If pending and (no CPU request or starve<STARVE_MAX): grant JTAG, going to JTAG_WR or JTAG_RD.
  - Else if CPU request: grant CPU, going to CPU_WR (write has priority if both avs_read and avs_write) or CPU_RD.
  - starve increments each IDLE cycle a CPU request is denied (saturating), and clears on CPU grant.
- CPU_WR: ram_addr=avs_address, ram_wren=1, ram_byteen=avs_byteenable, waitrequest=0. Next state IDLE. Write latency 2 cycles from request.
- CPU_RD → CPU_RSP: in CPU_RSP, avs_readdata=ram_rdata and waitrequest=0, then IDLE. Read latency 3 cycles.
- JTAG_WR: ram_wren=1, ram_byteen=4'hF, mon_dreg←jtag_wdata. JTAG_RD → JTAG_RSP: mon_dreg←ram_rdata.
- After JTAG_WR or JTAG_RSP: pointer←pointer+1 (wraps 2^ADDR_W-1→0), pending=0, mon_ready=1 the next cycle.
- avs_waitrequest = (avs_read|avs_write) & ~(state∈{CPU_WR,CPU_RSP}). With no request, waitrequest=0.
- ram_wren=0 in every state except CPU_WR and JTAG_WR.
- An Avalon master changing its request while waitrequest=1 is a protocol violation; behaviour is undefined.
- Reset mid-access: FSM returns to IDLE immediately, the pending JTAG access is lost, and no RAM write occurs in the reset cycle.

Optional Feature:
OCIMEM_ROM_PROTECT_EN
- Defined: CPU writes with avs_address MSB=1 complete normally (waitrequest=0 in CPU_WR) but force ram_wren=0. JTAG writes are unaffected.
- Undefined: all writes reach the RAM.

Decomposition:
- Package nios2_ocimem_pkg: FSM state enum, data width 32, byte-enable width 4.
- Sub-module nios2_ocimem_jtag_ptr: pending latch, pointer load/auto-increment/wrap, mon_error logic.

Test Plan:
- JTAG addr_set 0x10, write 0xDEADBEEF → RAM[0x10]=0xDEADBEEF, pointer=0x11, mon_ready high again 3 cycles after jtag_req. Then addr_set 0x10, read → mon_dreg=0xDEADBEEF.
- CPU read 0x20 (RAM=0x12345678), no JTAG activity → waitrequest low on cycle 3, avs_readdata=0x12345678.
- CPU read held while JTAG issues back-to-back accesses, STARVE_MAX=4 → CPU granted after at most 4 denied IDLE cycles, JTAG resumes afterwards.
- Pointer at 0xFF, JTAG read → pointer wraps to 0x00. jtag_req while busy → mon_error=1, cleared by the next accepted addr_set.
- reset asserted in CPU_RD with pending JTAG → IDLE, mon_ready=1, no RAM write, CPU read re-served after reset.
- With OCIMEM_ROM_PROTECT_EN, CPU write 0x80 ← 0x55 → waitrequest low, RAM unchanged. JTAG write 0x80 ← 0x55 → RAM updated.
